cv_mem_responder: RTL

- Memory-side responder for the loader request interface: serves rvalid/raddr read requests and wvalid/waddr/wdata write requests from the conv data loader.
- Answers each request with a one-cycle rready/wready pulse.
- Translates requests into accesses on a single-port synchronous SRAM backend with fixed read latency.
- Sits between the loader and on-chip feature/weight memory. Provides range checking, fair read/write arbitration and access counters for debug.

---
 rtl/cv_mem_responder.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/cv_mem_responder.sv
// cv_mem_responder
// Memory-side responder for the conv data loader. Accepts held read/write
// requests, arbitrates fairly between them, drives a single-port synchronous
// SRAM with a fixed read latency and answers each request with a one-cycle
// ready pulse. Out-of-range requests never reach the SRAM but still complete
// with normal timing; the first offending address is latched for debug.

module cv_mem_responder #(
    parameter int ADDR_W   = 16,   // SRAM word-address width (below 26)
    parameter int READ_LAT = 1     // SRAM read latency, 1..4 cycles
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rvalid,
    output logic              o_rready,
    input  logic [25:0]       i_raddr,
    output logic [31:0]       o_rdata,
    input  logic              i_wvalid,
    output logic              o_wready,
    input  logic [25:0]       i_waddr,
    input  logic [31:0]       i_wdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata,
    output logic              o_err,
    output logic [25:0]       o_err_addr,
    output logic [31:0]       o_rd_count,
    output logic [31:0]       o_wr_count
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_ISSUE = 3'd1,
        S_RD_WAIT  = 3'd2,
        S_RD_RESP  = 3'd3,
        S_WR_ISSUE = 3'd4,
        S_WR_RESP  = 3'd5
    } state_t;

    // Address bits above the SRAM range; any set bit makes a request invalid.
    localparam logic [25:0] HI_MASK  = ~((26'd1 << ADDR_W) - 26'd1);
    // Count value of the RD_WAIT cycle in which SRAM read data is valid.
    localparam logic [1:0]  LAT_LAST = 2'(READ_LAT - 1);

    // True when the word address lies outside the backend SRAM.
    function automatic logic f_out_of_range(input logic [25:0] addr);
        return |(addr & HI_MASK);
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_prio_wr;     // 0: read wins next contention
    logic [1:0]          r_lat_cnt;
    logic                r_oor;         // granted request is out of range

    logic                w_grant_rd;
    logic                w_grant_wr;
    logic                w_contend;
    logic [25:0]         w_req_addr;
    logic                w_req_oor;
    logic                w_rd_capture;
    logic                w_wr_done;

    logic                r_rready;
    logic                r_wready;
    logic [31:0]         r_rdata;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic                r_err;
    logic [25:0]         r_err_addr;
    logic [31:0]         r_rd_count;
    logic [31:0]         r_wr_count;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arbitration and next-state decode; requests are only looked at in IDLE.
    always_comb begin
        w_grant_rd  = 1'b0;
        w_grant_wr  = 1'b0;
        w_contend   = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                w_contend  = i_rvalid & i_wvalid;
                w_grant_rd = i_rvalid & (~i_wvalid | ~r_prio_wr);
                w_grant_wr = i_wvalid & (~i_rvalid |  r_prio_wr);
                if (w_grant_rd) begin
                    w_state_nxt = S_RD_ISSUE;
                end else if (w_grant_wr) begin
                    w_state_nxt = S_WR_ISSUE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD_ISSUE: w_state_nxt = S_RD_WAIT;
            S_RD_WAIT: begin
                if (r_lat_cnt == LAT_LAST) begin
                    w_state_nxt = S_RD_RESP;
                end else begin
                    w_state_nxt = S_RD_WAIT;
                end
            end
            S_RD_RESP:  w_state_nxt = S_IDLE;
            S_WR_ISSUE: w_state_nxt = S_WR_RESP;
            S_WR_RESP:  w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: strobes that load the registered outputs on the next edge.
    always_comb begin
        w_req_addr   = w_grant_rd ? i_raddr : i_waddr;
        w_req_oor    = f_out_of_range(w_req_addr);
        w_rd_capture = (r_state == S_RD_WAIT) && (r_lat_cnt == LAT_LAST);
        w_wr_done    = (r_state == S_WR_ISSUE);
    end

    // Fairness pointer: flips only when a grant resolved a real contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio_wr <= 1'b0;
        end else if (w_contend) begin
            r_prio_wr <= ~r_prio_wr;
        end else begin
            r_prio_wr <= r_prio_wr;
        end
    end

    // Read latency counter, running only while waiting for SRAM data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lat_cnt <= 2'd0;
        end else if (r_state == S_RD_WAIT) begin
            r_lat_cnt <= r_lat_cnt + 2'd1;
        end else begin
            r_lat_cnt <= 2'd0;
        end
    end

    // Backend interface registers; address/data hold between accesses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
            r_oor       <= 1'b0;
        end else begin
            r_mem_en <= (w_grant_rd | w_grant_wr) & ~w_req_oor;
            r_mem_we <= w_grant_wr & ~w_req_oor;
            if (w_grant_rd | w_grant_wr) begin
                r_oor <= w_req_oor;
            end else begin
                r_oor <= r_oor;
            end
            if ((w_grant_rd | w_grant_wr) && !w_req_oor) begin
                r_mem_addr <= w_req_addr[ADDR_W-1:0];
            end else begin
                r_mem_addr <= r_mem_addr;
            end
            if (w_grant_wr && !w_req_oor) begin
                r_mem_wdata <= i_wdata;
            end else begin
                r_mem_wdata <= r_mem_wdata;
            end
        end
    end

    // Loader-side responses, counters and sticky range error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rready   <= 1'b0;
            r_wready   <= 1'b0;
            r_rdata    <= 32'd0;
            r_rd_count <= 32'd0;
            r_wr_count <= 32'd0;
            r_err      <= 1'b0;
            r_err_addr <= 26'd0;
        end else begin
            r_rready <= w_rd_capture;
            r_wready <= w_wr_done;
            if (w_rd_capture) begin
                r_rdata    <= r_oor ? 32'd0 : i_mem_rdata;
                r_rd_count <= r_rd_count + 32'd1;
            end else begin
                r_rdata    <= r_rdata;
                r_rd_count <= r_rd_count;
            end
            if (w_wr_done) begin
                r_wr_count <= r_wr_count + 32'd1;
            end else begin
                r_wr_count <= r_wr_count;
            end
            if ((w_grant_rd | w_grant_wr) && w_req_oor) begin
                r_err <= 1'b1;
                if (!r_err) begin
                    r_err_addr <= w_req_addr;
                end else begin
                    r_err_addr <= r_err_addr;
                end
            end else begin
                r_err      <= r_err;
                r_err_addr <= r_err_addr;
            end
        end
    end

    assign o_rready    = r_rready;
    assign o_wready    = r_wready;
    assign o_rdata     = r_rdata;
    assign o_mem_en    = r_mem_en;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_err       = r_err;
    assign o_err_addr  = r_err_addr;
    assign o_rd_count  = r_rd_count;
    assign o_wr_count  = r_wr_count;

endmodule
